switch_round_judge: RTL

Round controller and judge for the switch game. It requests a prompt from the prompt generator, then watches the player's switches against the latched expected arrangement and enforces the per-round countdown. It scores passed rounds with doubling bonuses, inserts a rest gap between rounds, and ends the game on a wrong switch or a timeout. It sits between the board I/O (SW, KEY, LEDR) and the prompt generator, and it drives the timer and score digits feeding the HexDisplay decoders.

---
 rtl/switch_round_judge_if.sv | 11 +
 rtl/switch_round_judge.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/switch_round_judge_if.sv
// Prompt request/response bundle between the round judge and the prompt generator.
// One-cycle request pulse out; one-cycle valid pulse back carrying expected/target.
interface switch_round_judge_if;
  logic       prompt_req;
  logic       prompt_valid;
  logic [9:0] expected;
  logic [9:0] target;

  modport master (output prompt_req, input prompt_valid, input expected, input target);
  modport slave  (input prompt_req, output prompt_valid, output expected, output target);
endinterface

// File: rtl/switch_round_judge.sv
// Switch game round controller: requests prompts, judges switch changes against the latched answer, runs the countdown and scores.
// Pin change is judged two edges after it is sampled; the generator may answer at any time, and start restarts from any state.
module switch_round_judge #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int ROUND_SECS    = 15,
  parameter int GAP_SECS      = 5,
  parameter int SCORE_W       = 10
) (
  input  logic                 clk,
  input  logic                 reset_btn,
  input  logic                 start,
  input  logic [9:0]           sw,
  switch_round_judge_if.master prompt,
  output logic [9:0]           ledr,
  output logic [5:0]           seconds_left,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   best_score,
  output logic [7:0]           rounds,
  output logic                 playing,
  output logic                 game_over
);

  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
  localparam int SUM_W = ((SCORE_W > 6) ? SCORE_W : 6) + 1;
  localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'((2 ** SCORE_W) - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, PLAY, GAP, OVER} state_t;

  state_t          state, state_n;
  logic [9:0]      sw_m, sw_s, sw_p;
  logic [9:0]      exp_r, tgt_r;
  logic [TW-1:0]   tick_cnt;
  logic            change, tick, last_sec, counting;
  logic            clr_game, load_prompt, do_pass, do_over, do_dec;
  logic [7:0]      r_div5;
  logic [2:0]      tier;
  logic [5:0]      award;
  logic [SUM_W-1:0] score_sum;
  logic [SCORE_W-1:0] score_next;

  always_ff @(posedge clk or posedge reset_btn) begin
    if (reset_btn) begin
      sw_m <= '0;
      sw_s <= '0;
      sw_p <= '0;
    end else begin
      sw_m <= sw;
      sw_s <= sw_m;
      sw_p <= sw_s;
    end
  end

  assign change   = (sw_s != sw_p);
  assign tick     = (tick_cnt == TICK_LAST);
  assign last_sec = (seconds_left == 6'd1);
  assign counting = (state == PLAY) || (state == GAP);

  // Bonus doubles every five passed rounds, capped at the fifth tier.
  assign r_div5     = rounds / 8'd5;
  assign tier       = (r_div5 > 8'd4) ? 3'd4 : r_div5[2:0];
  assign award      = 6'd2 << tier;
  assign score_sum  = SUM_W'(score) + SUM_W'(award);
  assign score_next = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

  always_ff @(posedge clk or posedge reset_btn) begin
    if (reset_btn) state <= IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n     = state;
    clr_game    = 1'b0;
    load_prompt = 1'b0;
    do_pass     = 1'b0;
    do_over     = 1'b0;
    do_dec      = 1'b0;
    if (start) begin
      state_n  = REQ;
      clr_game = 1'b1;
    end else begin
      case (state)
        IDLE: state_n = IDLE;
        REQ:  state_n = WAIT;
        WAIT: if (prompt.prompt_valid) begin
          state_n     = PLAY;
          load_prompt = 1'b1;
        end
        // A switch verdict outranks a coincident final tick.
        PLAY: if (change) begin
          if (sw_s == exp_r) begin
            state_n = GAP;
            do_pass = 1'b1;
          end else begin
            state_n = OVER;
            do_over = 1'b1;
          end
        end else if (tick) begin
          do_dec = 1'b1;
          if (last_sec) begin
            state_n = OVER;
            do_over = 1'b1;
          end
        end
        GAP: if (tick) begin
          do_dec = 1'b1;
          if (last_sec) state_n = REQ;
        end
        OVER:    state_n = OVER;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_btn) begin
    if (reset_btn) begin
      tick_cnt     <= '0;
      seconds_left <= '0;
      exp_r        <= '0;
      tgt_r        <= '0;
      score        <= '0;
      best_score   <= '0;
      rounds       <= '0;
    end else begin
      if (load_prompt || do_pass || !counting || tick) tick_cnt <= '0;
      else                                             tick_cnt <= tick_cnt + 1'b1;

      if (load_prompt)  seconds_left <= 6'(ROUND_SECS);
      else if (do_pass) seconds_left <= 6'(GAP_SECS);
      else if (do_dec)  seconds_left <= seconds_left - 6'd1;

      if (load_prompt) begin
        exp_r <= prompt.expected;
        tgt_r <= prompt.target;
      end

      if (clr_game) begin
        score  <= '0;
        rounds <= '0;
      end else if (do_pass) begin
        score  <= score_next;
        rounds <= (rounds == 8'hFF) ? rounds : rounds + 8'd1;
      end

      if (do_over && (score > best_score)) best_score <= score;
    end
  end

  always_comb begin
    ledr = 10'b0;
    case (state)
      PLAY:    ledr = tgt_r;
      OVER:    ledr = 10'h3FF;
      default: ledr = 10'b0;
    endcase
  end

  assign prompt.prompt_req = (state == REQ);
  assign playing           = (state == PLAY);
  assign game_over         = (state == OVER);

endmodule
